// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner states, column constants and the optional key-code map (KEYPAD_CODE_EN)
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  localparam logic [3:0] COL0 = 4'b1000;
  localparam logic [3:0] COL1 = 4'b0100;
  localparam logic [3:0] COL2 = 4'b0010;
  localparam logic [3:0] COL3 = 4'b0001;
  function automatic logic [3:0] rot_col(input logic [3:0] c);
    return {c[0], c[3:1]};
  endfunction
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    return v == COL0 ? 2'd0 : v == COL1 ? 2'd1 : v == COL2 ? 2'd2 : v == COL3 ? 2'd3 : 2'd0;
  endfunction
`ifdef KEYPAD_CODE_EN
  localparam logic [3:0] KEY_MAP [16] = '{4'h1, 4'h4, 4'h7, 4'hE,
                                          4'h2, 4'h5, 4'h8, 4'h0,
                                          4'h3, 4'h6, 4'h9, 4'hF,
                                          4'hA, 4'hB, 4'hC, 4'hD};
  function automatic logic [3:0] key_code(input logic [3:0] row, input logic [3:0] col);
    return KEY_MAP[{onehot_idx(col), onehot_idx(row)}];
  endfunction
`endif
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins and decoded-key outputs; o_KeyCode exists only with KEYPAD_CODE_EN
interface keypad_scanner_if;
  logic [3:0] i_Row;
  logic [3:0] o_Col;
  logic [3:0] o_ScanRow;
  logic [3:0] o_ScanCol;
  logic       o_KeyValid;
  logic       o_KeyHeld;
  logic       o_Release;
`ifdef KEYPAD_CODE_EN
  logic [3:0] o_KeyCode;
  modport master (input i_Row, output o_Col, o_ScanRow, o_ScanCol, o_KeyValid, o_KeyHeld, o_Release, o_KeyCode);
  modport slave (output i_Row, input o_Col, o_ScanRow, o_ScanCol, o_KeyValid, o_KeyHeld, o_Release, o_KeyCode);
`else
  modport master (input i_Row, output o_Col, o_ScanRow, o_ScanCol, o_KeyValid, o_KeyHeld, o_Release);
  modport slave (output i_Row, input o_Col, o_ScanRow, o_ScanCol, o_KeyValid, o_KeyHeld, o_Release);
`endif
endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchronizer for the asynchronous 4-bit row lines
module keypad_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta;
  always_ff @(posedge clk) begin
    if (rst) {q, meta} <= '0;
    else     {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scan with press/release debounce; KEYPAD_CODE_EN adds o_KeyCode
import keypad_pkg::*;
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 20
) (
  input logic i_clk,
  input logic i_rst,
  keypad_scanner_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CNT);
  state_t state, state_n;
  logic [DW-1:0] div;
  logic [CW-1:0] dbcnt, dbcnt_n, relcnt, relcnt_n;
  logic [3:0] row, col, col_n, srow, srow_n, scol, scol_n;
  logic valid, valid_n, held, held_n, rel, rel_n, tick;
  keypad_sync u_sync (.clk(i_clk), .rst(i_rst), .d(kp.i_Row), .q(row));
  assign tick = div == DIV_LAST;
  always_comb begin
    state_n = state;
    col_n = col;
    srow_n = srow;
    scol_n = scol;
    dbcnt_n = dbcnt;
    relcnt_n = relcnt;
    valid_n = 1'b0;
    rel_n = 1'b0;
    held_n = held;
    if (tick) begin
      case (state)
        SCAN: begin
          if ($onehot(row)) begin
            srow_n = row;
            scol_n = col;
            dbcnt_n = CW'(1);
            valid_n = DEBOUNCE_CNT == 1;
            held_n = DEBOUNCE_CNT == 1;
            state_n = DEBOUNCE_CNT == 1 ? HELD : DEBOUNCE;
          end else begin
            col_n = rot_col(col);
          end
        end
        DEBOUNCE: begin
          if (row == srow) begin
            dbcnt_n = dbcnt + CW'(1);
            valid_n = dbcnt_n == DB_LAST;
            held_n = dbcnt_n == DB_LAST;
            state_n = dbcnt_n == DB_LAST ? HELD : DEBOUNCE;
          end else begin
            srow_n = '0;
            scol_n = '0;
            dbcnt_n = '0;
            col_n = rot_col(col);
            state_n = SCAN;
          end
        end
        HELD: begin
          relcnt_n = row == srow ? '0 : relcnt + CW'(1);
          if (relcnt_n == DB_LAST) begin
            rel_n = 1'b1;
            held_n = 1'b0;
            srow_n = '0;
            scol_n = '0;
            dbcnt_n = '0;
            relcnt_n = '0;
            col_n = rot_col(col);
            state_n = SCAN;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= SCAN;
      div <= '0;
      col <= COL0;
      srow <= '0;
      scol <= '0;
      dbcnt <= '0;
      relcnt <= '0;
      valid <= 1'b0;
      held <= 1'b0;
      rel <= 1'b0;
    end else begin
      state <= state_n;
      div <= tick ? '0 : div + DW'(1);
      col <= col_n;
      srow <= srow_n;
      scol <= scol_n;
      dbcnt <= dbcnt_n;
      relcnt <= relcnt_n;
      valid <= valid_n;
      held <= held_n;
      rel <= rel_n;
    end
  end
  assign kp.o_Col = col;
  assign kp.o_ScanRow = srow;
  assign kp.o_ScanCol = scol;
  assign kp.o_KeyValid = valid;
  assign kp.o_KeyHeld = held;
  assign kp.o_Release = rel;
`ifdef KEYPAD_CODE_EN
  logic [3:0] code;
  always_ff @(posedge i_clk) begin
    if (i_rst) code <= '0;
    else       code <= held_n ? key_code(srow_n, scol_n) : '0;
  end
  assign kp.o_KeyCode = code;
`endif
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan order, debounce, release, bounce, multi-row and reset
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] key_col = '0;
  logic [3:0] key_row = '0;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int vcnt = 0;
  int rcnt = 0;
  int ovl = 0;
  keypad_scanner_if kp ();
  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (.i_clk(clk), .i_rst(rst), .kp(kp));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst) begin
      vcnt += int'(kp.o_KeyValid);
      rcnt += int'(kp.o_Release);
      ovl += int'(kp.o_KeyValid && kp.o_Release);
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic drive_row();
    kp.i_Row = (kp.o_Col == key_col) ? key_row : 4'b0;
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    drive_row();
  endtask
  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    key_col = '0;
    key_row = '0;
    kp.i_Row = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    vcnt = 0;
    rcnt = 0;
    drive_row();
  endtask
  task automatic check_code(input string tag, input logic [3:0] exp);
`ifdef KEYPAD_CODE_EN
    check(tag, kp.o_KeyCode, exp);
`else
    check(tag, 4'(kp.o_KeyHeld ? 4'h8 : 4'h0), exp);
`endif
  endtask
  initial begin
    kp.i_Row = '0;
    do_reset();
    check("rst_col", kp.o_Col, 4'b1000);
    check("rst_srow", kp.o_ScanRow, 4'b0);
    check("rst_scol", kp.o_ScanCol, 4'b0);
    check("rst_held", kp.o_KeyHeld, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (c != 0) step();
      check("idle_col", kp.o_Col, 4'b1000 >> ((c / 4) % 4));
    end
    check("idle_valid_cnt", vcnt, 0);
    check("idle_rel_cnt", rcnt, 0);
    do_reset();
    key_col = 4'b0100;
    key_row = 4'b0010;
    run_to(8);
    check("cap_srow", kp.o_ScanRow, 4'b0010);
    check("cap_scol", kp.o_ScanCol, 4'b0100);
    check("cap_col_frozen", kp.o_Col, 4'b0100);
    run_to(15);
    check("pre_valid", kp.o_KeyValid, 1'b0);
    check("pre_held", kp.o_KeyHeld, 1'b0);
    step();
    check("press_valid", kp.o_KeyValid, 1'b1);
    check("press_held", kp.o_KeyHeld, 1'b1);
    check("press_scol", kp.o_ScanCol, 4'b0100);
    check("press_srow", kp.o_ScanRow, 4'b0010);
    check("press_col", kp.o_Col, 4'b0100);
    check_code("press_code", 4'h8);
    step();
    check("post_valid", kp.o_KeyValid, 1'b0);
    check("post_held", kp.o_KeyHeld, 1'b1);
    run_to(20);
    check("press_valid_cnt", vcnt, 1);
    key_col = '0;
    key_row = '0;
    drive_row();
    run_to(31);
    check("prerel_rel", kp.o_Release, 1'b0);
    check("prerel_held", kp.o_KeyHeld, 1'b1);
    step();
    check("rel_pulse", kp.o_Release, 1'b1);
    check("rel_held", kp.o_KeyHeld, 1'b0);
    check("rel_col", kp.o_Col, 4'b0010);
    check("rel_srow", kp.o_ScanRow, 4'b0);
    check("rel_scol", kp.o_ScanCol, 4'b0);
    check_code("rel_code", 4'h0);
    step();
    check("rel_once", kp.o_Release, 1'b0);
    check("rel_cnt", rcnt, 1);
    do_reset();
    key_col = 4'b0100;
    key_row = 4'b0010;
    run_to(8);
    check("bounce_cap", kp.o_ScanRow, 4'b0010);
    key_col = '0;
    key_row = '0;
    drive_row();
    run_to(12);
    check("bounce_col", kp.o_Col, 4'b0010);
    check("bounce_srow", kp.o_ScanRow, 4'b0);
    check("bounce_scol", kp.o_ScanCol, 4'b0);
    run_to(24);
    check("bounce_valid_cnt", vcnt, 0);
    do_reset();
    key_col = 4'b1000;
    key_row = 4'b0110;
    drive_row();
    for (int c = 0; c < 36; c++) begin
      if (c != 0) step();
      check("multi_col", kp.o_Col, 4'b1000 >> ((c / 4) % 4));
    end
    check("multi_srow", kp.o_ScanRow, 4'b0);
    check("multi_valid_cnt", vcnt, 0);
    do_reset();
    key_col = 4'b0100;
    key_row = 4'b0010;
    run_to(18);
    check("hr_held", kp.o_KeyHeld, 1'b1);
    rst = 1'b1;
    key_col = '0;
    key_row = '0;
    step();
    check("hr_col", kp.o_Col, 4'b1000);
    check("hr_held_clr", kp.o_KeyHeld, 1'b0);
    check("hr_valid", kp.o_KeyValid, 1'b0);
    check("hr_rel", kp.o_Release, 1'b0);
    check("hr_srow", kp.o_ScanRow, 4'b0);
    check("hr_scol", kp.o_ScanCol, 4'b0);
    check_code("hr_code", 4'h0);
    rst = 1'b0;
    run_to(40);
    check("hr_rel_cnt", rcnt, 0);
    check("hr_held_after", kp.o_KeyHeld, 1'b0);
    check("overlap_cnt", ovl, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
